// File: rtl/alu_result_stage_pkg.sv
// alu_defs: shared opcodes, branch codes, buffer states and opcode legality check
package alu_defs;
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOT   = 4'b0101;
  localparam logic [3:0] OP_SLL   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_PASSB = 4'b1100;
  localparam logic [2:0] BR_NEVER  = 3'b000;
  localparam logic [2:0] BR_Z      = 3'b001;
  localparam logic [2:0] BR_NZ     = 3'b010;
  localparam logic [2:0] BR_N      = 3'b011;
  localparam logic [2:0] BR_NN     = 3'b100;
  localparam logic [2:0] BR_C      = 3'b101;
  localparam logic [2:0] BR_NC     = 3'b110;
  localparam logic [2:0] BR_ALWAYS = 3'b111;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_e;
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_SRA) || (op == OP_PASSB);
  endfunction
endpackage

// File: rtl/alu_result_stage_result_buffer2.sv
// result_buffer2: 2-entry valid/ready skid buffer, FIFO order
//   in_valid_i/in_data_i/in_ready_o   : producer side (in_ready_o from registered state only)
//   out_valid_o/out_data_o/out_ready_i : consumer side (out_data_o holds when not valid)
module result_buffer2 import alu_defs::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);
  buf_state_e       state_q;
  logic [WIDTH-1:0] head_q, tail_q;
  assign in_ready_o  = state_q != FULL;
  assign out_valid_o = state_q != EMPTY;
  assign out_data_o  = head_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: if (in_valid_i) begin
          head_q  <= in_data_i;
          state_q <= ONE;
        end
        ONE: if (in_valid_i && out_ready_i) head_q <= in_data_i;
        else if (in_valid_i) begin
          tail_q  <= in_data_i;
          state_q <= FULL;
        end else if (out_ready_i) state_q <= EMPTY;
        FULL: if (out_ready_i) begin
          head_q  <= tail_q;
          state_q <= ONE;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registers ALU results into a 2-entry buffer, keeps Z/N/C flags, evaluates branches
//   CLK/Reset            : clock, synchronous active-high reset
//   input_*              : ALU result, flags, opcode, capture/flag-write strobes, branch selector, consumer ready
//   output_Ready/Valid/ALUOut : buffer handshake and head entry
//   output_Zero/Negative/Carry/BranchTaken/IllegalOp : flag register, branch decision, sticky illegal-op
module alu_result_stage import alu_defs::*; #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] input_ALU,
  input  logic             input_Zero,
  input  logic             input_Negative,
  input  logic             input_Carry,
  input  logic [OPW-1:0]   input_ALUOp,
  input  logic             input_Valid,
  input  logic             input_FlagWrite,
  input  logic [2:0]       input_BranchCond,
  input  logic             input_Ready,
  output logic             output_Ready,
  output logic             output_Valid,
  output logic [WIDTH-1:0] output_ALUOut,
  output logic             output_Zero,
  output logic             output_Negative,
  output logic             output_Carry,
  output logic             output_BranchTaken,
  output logic             output_IllegalOp
);
  logic       accept, legal, z_q, n_q, c_q, ill_q;
  logic [7:0] cond;
  result_buffer2 #(.WIDTH(WIDTH)) u_buf (
    .clk         (CLK),
    .rst         (Reset),
    .in_valid_i  (input_Valid),
    .in_data_i   (input_ALU),
    .in_ready_o  (output_Ready),
    .out_valid_o (output_Valid),
    .out_data_o  (output_ALUOut),
    .out_ready_i (input_Ready)
  );
  assign accept = input_Valid && output_Ready;
  assign legal  = is_legal_op(input_ALUOp);
  always_ff @(posedge CLK) begin
    if (Reset) begin
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      c_q   <= 1'b0;
      ill_q <= 1'b0;
    end else if (accept) begin
      if (!legal) ill_q <= 1'b1;
      else if (input_FlagWrite) begin
        z_q <= input_Zero;
        n_q <= input_Negative;
        // only add/sub produce a meaningful carry; logic/shift ops keep the old one
        c_q <= (input_ALUOp == OP_ADD || input_ALUOp == OP_SUB) ? input_Carry : c_q;
      end
    end
  end
  // indexed by branch code: never, Z, !Z, N, !N, C, !C, always
  assign cond               = {1'b1, !c_q, c_q, !n_q, n_q, !z_q, z_q, 1'b0};
  assign output_BranchTaken = cond[input_BranchCond];
  assign output_Zero        = z_q;
  assign output_Negative    = n_q;
  assign output_Carry       = c_q;
  assign output_IllegalOp   = ill_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: queue-based reference model, per-cycle compare, directed and random stimulus
module tb_alu_result_stage;
  logic        CLK = 0, Reset = 1;
  logic [15:0] input_ALU = 0;
  logic        input_Zero = 0, input_Negative = 0, input_Carry = 0;
  logic [3:0]  input_ALUOp = 0;
  logic        input_Valid = 0, input_FlagWrite = 0, input_Ready = 0;
  logic [2:0]  input_BranchCond = 0;
  logic        output_Ready, output_Valid, output_Zero, output_Negative, output_Carry;
  logic        output_BranchTaken, output_IllegalOp;
  logic [15:0] output_ALUOut;

  alu_result_stage #(.WIDTH(16), .OPW(4)) dut (
    .CLK(CLK), .Reset(Reset), .input_ALU(input_ALU), .input_Zero(input_Zero),
    .input_Negative(input_Negative), .input_Carry(input_Carry), .input_ALUOp(input_ALUOp),
    .input_Valid(input_Valid), .input_FlagWrite(input_FlagWrite), .input_BranchCond(input_BranchCond),
    .input_Ready(input_Ready), .output_Ready(output_Ready), .output_Valid(output_Valid),
    .output_ALUOut(output_ALUOut), .output_Zero(output_Zero), .output_Negative(output_Negative),
    .output_Carry(output_Carry), .output_BranchTaken(output_BranchTaken), .output_IllegalOp(output_IllegalOp)
  );

  always #5 CLK = ~CLK;

  int checks = 0, fails = 0;
  bit run = 0;
  logic [15:0] q[$], cons[$];
  logic [15:0] m_out = 0;
  logic mz = 0, mn = 0, mc = 0, mill = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic legal_op(input logic [3:0] op);
    return op inside {[4'd0:4'd8], 4'd12};
  endfunction

  function automatic logic branch(input logic [2:0] bc, input logic z, input logic n, input logic c);
    case (bc)
      3'd0: return 1'b0;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return c;
      3'd6: return !c;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (Reset) begin
      q.delete();
      m_out = 0;
      {mz, mn, mc, mill} = 4'b0;
    end else begin
      bit acc, pop;
      acc = input_Valid && q.size() < 2;
      pop = q.size() > 0 && input_Ready;
      if (acc) begin
        if (!legal_op(input_ALUOp)) mill = 1;
        else if (input_FlagWrite) begin
          mz = input_Zero;
          mn = input_Negative;
          if (input_ALUOp < 2) mc = input_Carry;
        end
      end
      if (pop) cons.push_back(q.pop_front());
      if (acc) q.push_back(input_ALU);
      if (q.size() > 0) m_out = q[0];
    end
  end

  always @(negedge CLK) if (run) begin
    chk("valid", output_Valid, q.size() > 0);
    chk("ready", output_Ready, q.size() < 2);
    chk("aluout", output_ALUOut, m_out);
    chk("zero", output_Zero, mz);
    chk("neg", output_Negative, mn);
    chk("carry", output_Carry, mc);
    chk("illegal", output_IllegalOp, mill);
    chk("branch", output_BranchTaken, branch(input_BranchCond, mz, mn, mc));
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] op, input logic z, input logic n,
                      input logic c, input logic fw);
    input_Valid = 1; input_ALU = d; input_ALUOp = op;
    input_Zero = z; input_Negative = n; input_Carry = c; input_FlagWrite = fw;
  endtask

  initial begin
    int drops, base;
    run = 1;
    step(); step();
    Reset = 0;
    // add wraparound
    push(16'h0000, 4'b0000, 1, 0, 1, 1);
    step();
    input_Valid = 0;
    chk("add_valid", output_Valid, 1);
    chk("add_out", output_ALUOut, 16'h0000);
    chk("add_z", output_Zero, 1);
    chk("add_c", output_Carry, 1);
    chk("add_n", output_Negative, 0);
    input_BranchCond = 3'b001; #1 chk("add_br_z", output_BranchTaken, 1);
    input_BranchCond = 3'b010; #1 chk("add_br_nz", output_BranchTaken, 0);
    // AND keeps carry
    input_Ready = 1;
    push(16'h8000, 4'b0010, 0, 1, 0, 1);
    step();
    input_Valid = 0;
    chk("and_out", output_ALUOut, 16'h8000);
    chk("and_n", output_Negative, 1);
    chk("and_z", output_Zero, 0);
    chk("and_c_hold", output_Carry, 1);
    input_BranchCond = 3'b101; #1 chk("and_br_c", output_BranchTaken, 1);
    input_BranchCond = 3'b011; #1 chk("and_br_n", output_BranchTaken, 1);
    step();
    // backpressure
    cons.delete();
    input_Ready = 0;
    push(16'h1111, 4'b0011, 0, 0, 0, 0); step();
    push(16'h2222, 4'b0011, 0, 0, 0, 0); step();
    chk("bp_full_ready", output_Ready, 0);
    push(16'h3333, 4'b0011, 0, 0, 0, 0); step(); step();
    chk("bp_held_ready", output_Ready, 0);
    chk("bp_head", output_ALUOut, 16'h1111);
    input_Ready = 1;
    step(); step();
    input_Valid = 0;
    repeat (4) step();
    chk("bp_count", cons.size(), 3);
    if (cons.size() == 3) begin
      chk("bp_0", cons[0], 16'h1111);
      chk("bp_1", cons[1], 16'h2222);
      chk("bp_2", cons[2], 16'h3333);
    end
    // streaming
    base = cons.size();
    drops = 0;
    for (int i = 0; i < 8; i++) begin
      push(16'hA000 + 16'(i), 4'b0100, 0, 0, 0, 0);
      step();
      if (!output_Ready) drops++;
      chk("stream_lat", output_ALUOut, 16'hA000 + 16'(i));
    end
    input_Valid = 0;
    step();
    chk("stream_drops", drops, 0);
    chk("stream_count", cons.size() - base, 8);
    // illegal opcode
    push(16'h5A5A, 4'b1010, 1, 0, 0, 1);
    step();
    input_Valid = 0;
    chk("ill_set", output_IllegalOp, 1);
    chk("ill_z_hold", output_Zero, 0);
    chk("ill_entry", output_ALUOut, 16'h5A5A);
    push(16'h0001, 4'b1100, 0, 0, 0, 1);
    step();
    input_Valid = 0;
    step();
    chk("ill_sticky", output_IllegalOp, 1);
    chk("ill_delivered", cons[cons.size()-2], 16'h5A5A);
    // random
    for (int i = 0; i < 400; i++) begin
      Reset = ($urandom_range(0, 59) == 0);
      input_Valid = $urandom_range(0, 2) != 0;
      input_Ready = $urandom_range(0, 2) != 0;
      input_ALU = 16'($urandom);
      input_ALUOp = 4'($urandom_range(0, 15));
      {input_Zero, input_Negative, input_Carry, input_FlagWrite} = 4'($urandom);
      input_BranchCond = 3'($urandom);
      step();
    end
    Reset = 0;
    // reset with two entries held
    input_Ready = 0;
    push(16'hBEEF, 4'b0000, 1, 1, 1, 1); step();
    push(16'hCAFE, 4'b1111, 0, 0, 0, 1); step();
    input_Valid = 0;
    chk("pre_rst_ready", output_Ready, 0);
    chk("pre_rst_ill", output_IllegalOp, 1);
    Reset = 1;
    step(); step();
    chk("rst_valid", output_Valid, 0);
    chk("rst_out", output_ALUOut, 16'h0000);
    chk("rst_flags", {output_Zero, output_Negative, output_Carry}, 3'b000);
    chk("rst_ill", output_IllegalOp, 0);
    chk("rst_ready", output_Ready, 1);
    Reset = 0;
    step(); step();
    run = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
